// File: rtl/sram_like_arbiter.sv
// Two-port sram-like arbiter: inst and data ports share one master port.
// Data wins ties unless inst has waited STARVE_LIMIT consecutive data grants.
module sram_like_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t        state;
  logic          own_inst;
  logic [CW-1:0] starve_cnt;

  logic any_req;
  logic grant_inst;
  logic sel_inst;
  logic done;

  assign any_req    = inst_req | data_req;
  assign grant_inst = inst_req & (~data_req | (starve_cnt == LIM));
  // In IDLE the fresh winner steers the bus; afterwards the latched owner.
  assign sel_inst   = (state == IDLE) ? grant_inst : own_inst;

  assign m_req   = ~rst & (((state == IDLE) & any_req) | (state == ADDR));
  assign m_wr    = sel_inst ? inst_wr    : data_wr;
  assign m_size  = sel_inst ? inst_size  : data_size;
  assign m_addr  = sel_inst ? inst_addr  : data_addr;
  assign m_wdata = sel_inst ? inst_wdata : data_wdata;

  assign inst_addr_ok = m_req & m_addr_ok & sel_inst;
  assign data_addr_ok = m_req & m_addr_ok & ~sel_inst;

  assign done         = ~rst & (state == DATA) & m_data_ok;
  assign inst_data_ok = done & own_inst;
  assign data_data_ok = done & ~own_inst;

  assign inst_rdata = m_rdata;
  assign data_rdata = m_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      own_inst   <= 1'b1;
      starve_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            own_inst <= grant_inst;
            if (grant_inst)
              starve_cnt <= '0;
            else if (inst_req && starve_cnt != LIM)
              starve_cnt <= starve_cnt + CW'(1);
            state <= m_addr_ok ? DATA : ADDR;
          end
        end
        ADDR: begin
          if (m_addr_ok)
            state <= DATA;
        end
        DATA: begin
          if (m_data_ok)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive data grants allowed while inst_req waits before inst is forced.
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 inst_req, inst_wr  in  1 each  instruction-port request and write flag.
REQ-005 inst_size  in  2, inst_addr  in  32, inst_wdata  in  32  instruction-port request fields.
REQ-006 inst_rdata  out  32, inst_addr_ok  out  1, inst_data_ok  out  1  instruction-port responses.
REQ-007 data_req, data_wr, data_size, data_addr, data_wdata / data_rdata, data_addr_ok, data_data_ok  same widths and directions as the inst_* signals  data-port sram-like slave.
REQ-008 m_req, m_wr  out  1, m_size  out  2, m_addr, m_wdata  out  32  shared master request.
REQ-009 m_rdata  in  32, m_addr_ok  in  1, m_data_ok  in  1  shared master responses.

Function
REQ-010 The block SHALL implement a 3-state FSM: IDLE, ADDR, DATA, with one outstanding master transaction at most.
REQ-011 The block SHALL record the owner of the granted transaction (INST or DATA) in a register, loaded in IDLE on grant.
REQ-012 Arbitration in IDLE: data_req alone -> DATA; inst_req alone -> INST; both -> DATA unless starve_cnt == STARVE_LIMIT, then INST.
REQ-013 In IDLE with any request, the block SHALL drive m_req=1 and the winner's wr/size/addr/wdata combinationally in the same cycle.
REQ-014 In IDLE with a grant, m_addr_ok=1 SHALL move to DATA; m_addr_ok=0 SHALL move to ADDR with the owner latched.
REQ-015 In ADDR, m_req SHALL stay 1 with the latched owner's live fields; the other port SHALL NOT be granted; m_addr_ok=1 -> DATA.
REQ-016 m_addr_ok SHALL be forwarded only to the owner's *_addr_ok, in IDLE and ADDR; the non-owner addr_ok SHALL be 0.
REQ-017 In DATA, m_req SHALL be 0; m_data_ok=1 SHALL pulse the owner's *_data_ok for that cycle and return to IDLE.
REQ-018 A new grant SHALL occur no earlier than the cycle after the data_ok cycle; there is no same-cycle grant on completion.
REQ-019 m_rdata SHALL drive both inst_rdata and data_rdata combinationally; only the *_data_ok qualifiers differ.
REQ-020 m_data_ok in IDLE or ADDR SHALL be ignored, and no *_data_ok SHALL assert.
REQ-021 starve_cnt (width clog2(STARVE_LIMIT+1)): +1 on a DATA grant while inst_req=1, saturating at STARVE_LIMIT; cleared on an INST grant; unchanged otherwise.
REQ-022 m_addr_ok=1 while no request is pending in IDLE SHALL be ignored, with no state change.
REQ-023 The requester is responsible for holding request fields until its addr_ok; the block SHALL NOT buffer request fields.

Reset
REQ-024 On rst=1 at posedge: state=IDLE, owner=INST, starve_cnt=0.
REQ-025 During rst=1, and in the cycle after release with no request, m_req, inst_addr_ok, data_addr_ok, inst_data_ok and data_data_ok SHALL all be 0.
REQ-026 Reset in ADDR or DATA SHALL abandon the transaction; a late m_data_ok after reset SHALL be dropped per REQ-020.

Verification
REQ-027 Scenario: inst_req=1 alone, addr 0xbfc00000, m_addr_ok=1 same cycle, m_data_ok 2 cycles later with m_rdata=0x3c08bfc0 -> inst_addr_ok pulse at cycle 0; inst_data_ok pulse at cycle 2 with inst_rdata=0x3c08bfc0; data_* oks stay 0.
REQ-028 Scenario: inst_req and data_req both 1, data_addr=0x80000010 -> m_addr=0x80000010, data_addr_ok only; after completion, inst is granted the next cycle.
REQ-029 Scenario: STARVE_LIMIT=4, both ports requesting continuously -> grant order D,D,D,D,I,D,D,D,D,I; starve_cnt saturates at 4 and clears on each I grant.
REQ-030 Scenario: m_addr_ok held 0 for 3 cycles after a data grant while inst_req rises -> m_addr stays the data address; no inst_addr_ok until the data transaction completes.
REQ-031 Scenario: rst pulsed in DATA, then m_data_ok=1 the cycle after release -> no *_data_ok; FSM in IDLE; the next request is granted normally.
REQ-032 Scenario: stray m_data_ok=1 in IDLE with no request -> all ok outputs 0; state unchanged.
